// File: rtl/memory_stage_if.sv
// memory_stage_if
//   Bundles the EX/MEM inputs, the hazard-unit controls and the MEM/WB outputs
//   of the MIPS MEM stage into one interface.
//   master : the pipeline side that produces EX/MEM values and consumes MEM/WB.
//   slave  : the MEM stage itself.
//   Signals:
//     ExMemAluOutput[31:0]          effective byte address or ALU result
//     ExMemReadData2[31:0]          store data (forwarded Rt)
//     ExMemDestination_Rt_RdOutput  destination register number
//     ExMemWriteRegEnable           instruction writes the register file
//     ExMemWriteMemoryEnable        store
//     ExMemReadMemoryEnable         load
//     ExMemwritebackRegCtrl         1 = write back load data, 0 = ALU result
//     Stall / Flush                 hazard-unit controls
//     MemWb*                        registered MEM/WB pipeline fields
//     WriteBackValue                combinational write-back mux output
//     MisalignedFault               registered one-cycle fault pulse
interface memory_stage_if;
    logic [31:0] ExMemAluOutput;
    logic [31:0] ExMemReadData2;
    logic [4:0]  ExMemDestination_Rt_RdOutput;
    logic        ExMemWriteRegEnable;
    logic        ExMemWriteMemoryEnable;
    logic        ExMemReadMemoryEnable;
    logic        ExMemwritebackRegCtrl;
    logic        Stall;
    logic        Flush;
    logic [31:0] MemWbAluOut;
    logic [31:0] MemWbReadData;
    logic [4:0]  MemWbDestination;
    logic        MemWbWriteRegEnable;
    logic        MemWbwritebackRegCtrl;
    logic [31:0] WriteBackValue;
    logic        MisalignedFault;

    modport master (
        output ExMemAluOutput, ExMemReadData2, ExMemDestination_Rt_RdOutput,
               ExMemWriteRegEnable, ExMemWriteMemoryEnable, ExMemReadMemoryEnable,
               ExMemwritebackRegCtrl, Stall, Flush,
        input  MemWbAluOut, MemWbReadData, MemWbDestination, MemWbWriteRegEnable,
               MemWbwritebackRegCtrl, WriteBackValue, MisalignedFault
    );

    modport slave (
        input  ExMemAluOutput, ExMemReadData2, ExMemDestination_Rt_RdOutput,
               ExMemWriteRegEnable, ExMemWriteMemoryEnable, ExMemReadMemoryEnable,
               ExMemwritebackRegCtrl, Stall, Flush,
        output MemWbAluOut, MemWbReadData, MemWbDestination, MemWbWriteRegEnable,
               MemWbwritebackRegCtrl, WriteBackValue, MisalignedFault
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage
//   MEM stage of the 5-stage MIPS core: word loads/stores against an internal
//   2**ADDR_WIDTH x 32 data memory, the MEM/WB pipeline register, the
//   write-back mux and a registered misaligned-access fault pulse.
//   Ports:
//     clk   : pipeline clock, all state updates on the rising edge
//     reset : asynchronous active-high reset of the MEM/WB register
//     bus   : memory_stage_if.slave (EX/MEM inputs, Stall/Flush, MEM/WB outputs)
module memory_stage #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    memory_stage_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] index_s;
    logic                  misaligned_s;
    logic                  store_s;
    logic                  reg_we_s;
    logic [31:0]           read_data_s;
    logic                  addr_unused_s;

    logic [31:0] alu_out_r;
    logic [31:0] read_data_r;
    logic [4:0]  dest_r;
    logic        reg_we_r;
    logic        wb_ctrl_r;
    logic        fault_r;

    // Address bits above the word index are deliberately ignored (wrap-around).
    assign addr_unused_s = ^bus.ExMemAluOutput[31:ADDR_WIDTH+2];

    // Decode word index, alignment, qualified store strobe, write enable and load data.
    always_comb begin
        index_s      = bus.ExMemAluOutput[ADDR_WIDTH+1:2];
        misaligned_s = 1'b0;
        store_s      = 1'b0;
        reg_we_s     = 1'b0;
        read_data_s  = 32'd0;
        if ((bus.ExMemAluOutput[1:0] != 2'b00) &&
            (bus.ExMemReadMemoryEnable || bus.ExMemWriteMemoryEnable)) begin
            misaligned_s = 1'b1;
        end else begin
            misaligned_s = 1'b0;
        end
        // A store is dropped while reset, stall or flush is active.
        if (bus.ExMemWriteMemoryEnable && !misaligned_s && !bus.Stall &&
            !bus.Flush && !reset) begin
            store_s = 1'b1;
        end else begin
            store_s = 1'b0;
        end
        if (bus.ExMemWriteRegEnable && !misaligned_s &&
            (bus.ExMemDestination_Rt_RdOutput != 5'd0)) begin
            reg_we_s = 1'b1;
        end else begin
            reg_we_s = 1'b0;
        end
        // Non-load and misaligned accesses capture zero so no stale or
        // uninitialised memory word reaches the pipeline register.
        if (bus.ExMemReadMemoryEnable && !misaligned_s) begin
            read_data_s = mem_r[index_s];
        end else begin
            read_data_s = 32'd0;
        end
    end

    // Data memory write port; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_r[index_s] <= bus.ExMemReadData2;
        end
    end

    // MEM/WB pipeline register: reset > flush > stall > capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out_r   <= 32'd0;
            read_data_r <= 32'd0;
            dest_r      <= 5'd0;
            reg_we_r    <= 1'b0;
            wb_ctrl_r   <= 1'b0;
            fault_r     <= 1'b0;
        end else if (bus.Flush) begin
            alu_out_r   <= 32'd0;
            read_data_r <= 32'd0;
            dest_r      <= 5'd0;
            reg_we_r    <= 1'b0;
            wb_ctrl_r   <= 1'b0;
            fault_r     <= 1'b0;
        end else if (bus.Stall) begin
            fault_r     <= 1'b0;
        end else begin
            alu_out_r   <= bus.ExMemAluOutput;
            read_data_r <= read_data_s;
            dest_r      <= bus.ExMemDestination_Rt_RdOutput;
            reg_we_r    <= reg_we_s;
            wb_ctrl_r   <= bus.ExMemwritebackRegCtrl;
            fault_r     <= misaligned_s;
        end
    end

    assign bus.MemWbAluOut           = alu_out_r;
    assign bus.MemWbReadData         = read_data_r;
    assign bus.MemWbDestination      = dest_r;
    assign bus.MemWbWriteRegEnable   = reg_we_r;
    assign bus.MemWbwritebackRegCtrl = wb_ctrl_r;
    assign bus.MisalignedFault       = fault_r;
    assign bus.WriteBackValue        = wb_ctrl_r ? read_data_r : alu_out_r;
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    localparam int AW = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    memory_stage_if bus ();

    memory_stage #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: word-addressed memory image and expected MEM/WB fields.
    logic [31:0] mem_model [2**AW];
    logic [31:0] e_alu;
    logic [31:0] e_rd;
    logic [4:0]  e_dst;
    logic        e_we;
    logic        e_ctl;
    logic        e_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_expect();
        e_alu = 32'd0; e_rd = 32'd0; e_dst = 5'd0;
        e_we = 1'b0; e_ctl = 1'b0; e_fault = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".alu"},   bus.MemWbAluOut, e_alu);
        check({tag, ".rd"},    bus.MemWbReadData, e_rd);
        check({tag, ".dst"},   {27'd0, bus.MemWbDestination}, {27'd0, e_dst});
        check({tag, ".we"},    {31'd0, bus.MemWbWriteRegEnable}, {31'd0, e_we});
        check({tag, ".ctl"},   {31'd0, bus.MemWbwritebackRegCtrl}, {31'd0, e_ctl});
        check({tag, ".fault"}, {31'd0, bus.MisalignedFault}, {31'd0, e_fault});
        check({tag, ".wbv"},   bus.WriteBackValue, e_ctl ? e_rd : e_alu);
    endtask

    // Apply what the spec says happens at one rising edge, given the inputs held across it.
    task automatic model_edge();
        int   idx;
        logic mis;
        logic [31:0] old_word;
        idx      = int'((bus.ExMemAluOutput / 32'd4) % 32'(2**AW));
        mis      = (bus.ExMemAluOutput % 32'd4 != 32'd0) &&
                   (bus.ExMemReadMemoryEnable || bus.ExMemWriteMemoryEnable);
        old_word = mem_model[idx];
        if (reset) begin
            clear_expect();
        end else if (bus.Flush) begin
            clear_expect();
        end else if (bus.Stall) begin
            e_fault = 1'b0;
        end else begin
            e_alu   = bus.ExMemAluOutput;
            e_rd    = (bus.ExMemReadMemoryEnable && !mis) ? old_word : 32'd0;
            e_dst   = bus.ExMemDestination_Rt_RdOutput;
            e_we    = bus.ExMemWriteRegEnable && !mis && (bus.ExMemDestination_Rt_RdOutput != 5'd0);
            e_ctl   = bus.ExMemwritebackRegCtrl;
            e_fault = mis;
        end
        if (!reset && !bus.Flush && !bus.Stall && bus.ExMemWriteMemoryEnable && !mis) begin
            mem_model[idx] = bus.ExMemReadData2;
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dst,
                         input logic rwe, input logic mwe, input logic mre, input logic ctl,
                         input logic stall, input logic flush);
        bus.ExMemAluOutput               = addr;
        bus.ExMemReadData2               = wdata;
        bus.ExMemDestination_Rt_RdOutput = dst;
        bus.ExMemWriteRegEnable          = rwe;
        bus.ExMemWriteMemoryEnable       = mwe;
        bus.ExMemReadMemoryEnable        = mre;
        bus.ExMemwritebackRegCtrl        = ctl;
        bus.Stall                        = stall;
        bus.Flush                        = flush;
    endtask

    task automatic step(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] dst, input logic rwe, input logic mwe, input logic mre,
                        input logic ctl, input logic stall, input logic flush);
        drive(addr, wdata, dst, rwe, mwe, mre, ctl, stall, flush);
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] data);
        step(tag, addr, data, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [4:0] dst);
        step(tag, addr, 32'd0, dst, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_expect();
        for (int i = 0; i < 2**AW; i++) mem_model[i] = 32'd0;
        #12;
        check_all("reset_init");
        reset = 1'b0;

        // Give every word a known value so every later load is predictable.
        for (int i = 0; i < 2**AW; i++) begin
            store("init", 32'(i) * 32'd4, 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000);
        end

        // Store then load to r5 through the memory path.
        store("st_10", 32'h10, 32'hDEAD_BEEF);
        load("ld_10", 32'h10, 5'd5);
        check("ld_10.wbv_const", bus.WriteBackValue, 32'hDEAD_BEEF);
        check("ld_10.dst_const", {27'd0, bus.MemWbDestination}, 32'd5);
        check("ld_10.we_const", {31'd0, bus.MemWbWriteRegEnable}, 32'd1);

        // ALU pass-through, then the same to r0.
        step("alu_r3", 32'h1234_5678, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("alu_r3.wbv_const", bus.WriteBackValue, 32'h1234_5678);
        step("alu_r0", 32'h1234_5678, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("alu_r0.we_const", {31'd0, bus.MemWbWriteRegEnable}, 32'd0);

        // Misaligned load pulses the fault for one cycle; misaligned store is dropped.
        load("ld_13", 32'h13, 5'd7);
        check("ld_13.fault_const", {31'd0, bus.MisalignedFault}, 32'd1);
        idle("after_ld_13");
        check("after_ld_13.fault_const", {31'd0, bus.MisalignedFault}, 32'd0);
        store("st_22", 32'h22, 32'h55);
        load("ld_20", 32'h20, 5'd8);

        // Stall held 3 cycles, then release: store happens once.
        idle("pre_stall");
        for (int k = 0; k < 3; k++) begin
            step("st_40_stall", 32'h40, 32'hA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        store("st_40_go", 32'h40, 32'hA);
        load("ld_40", 32'h40, 5'd9);
        check("ld_40.wbv_const", bus.WriteBackValue, 32'hA);

        // Flush together with stall: bubble, no store.
        for (int k = 0; k < 3; k++) begin
            step("st_40_flush", 32'h40, 32'hB, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        load("ld_40_after_flush", 32'h40, 5'd9);
        check("ld_40_after_flush.wbv_const", bus.WriteBackValue, 32'hA);

        // Address wrap and simultaneous read/write.
        store("st_400", 32'h400, 32'h77);
        load("ld_000", 32'h000, 5'd10);
        check("ld_000.wbv_const", bus.WriteBackValue, 32'h77);
        store("st_08", 32'h8, 32'h1);
        step("rw_08", 32'h8, 32'h2, 5'd11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rw_08.rd_const", bus.MemWbReadData, 32'h1);
        load("ld_08", 32'h8, 5'd11);
        check("ld_08.wbv_const", bus.WriteBackValue, 32'h2);

        // Reset asserted mid-cycle during a store: immediate clear, no write.
        load("pre_rst", 32'h8, 5'd12);
        drive(32'h8, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        clear_expect();
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        model_edge();
        check_all("rst_edge");
        reset = 1'b0;
        idle("rst_idle");
        load("ld_08_post_rst", 32'h8, 5'd12);
        check("ld_08_post_rst.wbv_const", bus.WriteBackValue, 32'h2);

        // Randomised traffic over a small window of words with random upper bits.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] addr;
            int kind;
            addr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
            kind = $urandom_range(0, 3);
            step("rand", addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom),
                 (kind == 1) || (kind == 3), (kind == 0) || (kind == 3), 1'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
